// File: rtl/reliable_nand_arbiter.sv
// Round-robin arbiter/sequencer sharing one reliable_nand datapath among R requesters.
// Optional statistics counters are enabled by defining RELIABLE_NAND_ARB_STATS_EN.
module reliable_nand_arbiter #(
  parameter int N          = 10,
  parameter int R          = 4,
  parameter int DP_LATENCY = 1,
  parameter int HI_THRESH  = 8,
  parameter int LO_THRESH  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [R-1:0]         req_valid_i,
  input  logic [R*N-1:0]       req_x_i,
  input  logic [R*N-1:0]       req_y_i,
  output logic [R-1:0]         req_ready_o,
  input  logic                 hold_i,
  output logic [N-1:0]         dp_x_o,
  output logic [N-1:0]         dp_y_o,
  input  logic                 dp_valid_i,
  input  logic [N-1:0]         dp_z_i,
  output logic                 resp_valid_o,
  output logic [$clog2(R)-1:0] resp_id_o,
  output logic [N-1:0]         resp_z_o,
  output logic                 resp_bit_o,
  output logic                 resp_undet_o,
  output logic                 busy_o,
  output logic [15:0]          undet_count_o,
  output logic [15:0]          err_count_o
);

  localparam int          IDW  = $clog2(R);
  localparam int          PCW  = $clog2(N + 1);
  localparam int unsigned RU   = R;
  localparam int unsigned HI_U = HI_THRESH;
  localparam int unsigned LO_U = LO_THRESH;
  localparam logic [IDW-1:0] LAST_ID = IDW'(R - 1);

  typedef enum logic [1:0] {WARMUP, RUN, DRAIN, HALT} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [R-1:0]   grant;
  int unsigned    idx;
  logic [N-1:0]   gnt_x, gnt_y;

  logic [DP_LATENCY:0] tag_v;
  logic [IDW-1:0]      tag_id [DP_LATENCY+1];
  logic                out_v;
  logic [IDW-1:0]      out_id;

  logic [PCW-1:0] pop;
  logic           dec_bit, dec_undet;

  // Wrap-around search starting at ptr; reset also masks the grant so
  // req_ready_o is zero throughout a reset cycle.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (state == RUN && !hold_i && !reset) begin
      for (int unsigned k = 0; k < RU; k++) begin
        idx = (int'(ptr) + k) % RU;
        if (!grant_any && req_valid_i[idx[IDW-1:0]]) begin
          grant_any = 1'b1;
          grant_id  = idx[IDW-1:0];
        end
      end
    end
    if (grant_any) grant[grant_id] = 1'b1;
  end

  assign req_ready_o = grant;
  assign gnt_x       = req_x_i[int'(grant_id)*N +: N];
  assign gnt_y       = req_y_i[int'(grant_id)*N +: N];

  assign out_v  = tag_v[DP_LATENCY];
  assign out_id = tag_id[DP_LATENCY];
  assign busy_o = |tag_v;

  always_comb begin
    state_nxt = state;
    case (state)
      WARMUP:  if (dp_valid_i) state_nxt = RUN;
      RUN:     if (hold_i)     state_nxt = DRAIN;
      DRAIN:   if (!busy_o)    state_nxt = HALT;
      HALT:    if (!hold_i)    state_nxt = RUN;
      default:                 state_nxt = WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WARMUP;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_x_o <= '0;
      dp_y_o <= '0;
    end else if (grant_any) begin
      dp_x_o <= gnt_x;
      dp_y_o <= gnt_y;
    end
  end

  // Tag pipe: stage 0 aligns with dp_x_o, stage DP_LATENCY with dp_z_i.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
      for (int unsigned s = 0; s <= DP_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      tag_v     <= {tag_v[DP_LATENCY-1:0], grant_any};
      tag_id[0] <= grant_id;
      for (int unsigned s = 1; s <= DP_LATENCY; s++) tag_id[s] <= tag_id[s-1];
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N; i++) pop = pop + PCW'(dp_z_i[i]);
  end

  assign dec_bit   = (int'(pop) >= HI_U);
  assign dec_undet = !dec_bit && (int'(pop) > LO_U);

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_o <= 1'b0;
      resp_id_o    <= '0;
      resp_z_o     <= '0;
      resp_bit_o   <= 1'b0;
      resp_undet_o <= 1'b0;
    end else begin
      resp_valid_o <= out_v;
      if (out_v) begin
        resp_id_o    <= out_id;
        resp_z_o     <= dp_z_i;
        resp_bit_o   <= dec_bit;
        resp_undet_o <= dec_undet;
      end
    end
  end

`ifdef RELIABLE_NAND_ARB_STATS_EN
  logic [15:0] undet_cnt, err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      undet_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (out_v && dec_undet && undet_cnt != '1) undet_cnt <= undet_cnt + 16'd1;
      if (out_v && !dp_valid_i && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign undet_count_o = undet_cnt;
  assign err_count_o   = err_cnt;
`else
  assign undet_count_o = '0;
  assign err_count_o   = '0;
`endif

endmodule
